lfsr_byte_packer: RTL and testbench

Downstream stage for the Sierpinski LFSR generator: consumes its serial pseudo-random bit stream, packs bits into bytes, and buffers completed bytes in a small FIFO presented on a valid/ready interface. Decouples the free-running generator from a slower or stalling byte consumer, such as the output pin mux or a host readout path. Bytes that arrive while the FIFO is full are dropped and flagged with a sticky overflow.

---
 rtl/lfsr_byte_packer.sv | 114 +++++++++++
 tb/tb_lfsr_byte_packer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_byte_packer.sv
// Serial-to-byte packer with a small byte FIFO on a valid/ready output.
// Bytes completing while the FIFO is full (and not popping) are dropped and flag a sticky overflow.
module lfsr_byte_packer #(
  parameter int DEPTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       bit_in_i,
  input  logic                       bit_valid_i,
  output logic [7:0]                 byte_out_o,
  output logic                       byte_valid_o,
  input  logic                       byte_ready_i,
  output logic [$clog2(DEPTH):0]     fill_level_o,
  output logic [2:0]                 bit_count_o,
  output logic                       overflow_o,
  input  logic                       clear_ovf_i
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  logic [7:0]    partial_q, partial_d;
  logic [2:0]    bit_count_q, bit_count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   fill_q, fill_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    mem_q [DEPTH];

  logic [2:0]    bit_pos;
  logic [7:0]    packed_byte;
  logic          byte_done;
  logic          pop;
  logic          push;
  logic          drop;

  // The incoming bit is merged into the partial so the completing byte can be pushed on the same edge.
  always_comb begin
    bit_pos          = MSB_FIRST ? (3'd7 - bit_count_q) : bit_count_q;
    packed_byte      = partial_q;
    packed_byte[bit_pos] = bit_in_i;
    byte_done        = bit_valid_i && (bit_count_q == 3'd7);
    pop              = (fill_q != '0) && byte_ready_i;
    push             = byte_done && ((fill_q < FULL_LVL) || pop);
    drop             = byte_done && !push;
  end

  always_comb begin
    partial_d   = partial_q;
    bit_count_d = bit_count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fill_d      = fill_q;
    overflow_d  = overflow_q;

    if (bit_valid_i) begin
      bit_count_d = bit_count_q + 3'd1;
      partial_d   = byte_done ? 8'h00 : packed_byte;
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case ({push, pop})
      2'b10:   fill_d = fill_q + (AW + 1)'(1);
      2'b01:   fill_d = fill_q - (AW + 1)'(1);
      default: fill_d = fill_q;
    endcase

    // A drop on the same edge as a clear keeps the flag set.
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clear_ovf_i) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      partial_q   <= 8'h00;
      bit_count_q <= 3'd0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      overflow_q  <= 1'b0;
    end else begin
      partial_q   <= partial_d;
      bit_count_q <= bit_count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
      overflow_q  <= overflow_d;
    end
  end

  // Storage needs no reset: an empty FIFO masks the head to zero.
  always_ff @(posedge clk_i) begin
    if (!rst_i && push) begin
      mem_q[wr_ptr_q] <= packed_byte;
    end
  end

  assign byte_valid_o = (fill_q != '0);
  assign byte_out_o   = byte_valid_o ? mem_q[rd_ptr_q] : 8'h00;
  assign fill_level_o = fill_q;
  assign bit_count_o  = bit_count_q;
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_lfsr_byte_packer.sv
// Directed bench for lfsr_byte_packer: packing order, fill/overflow, full+pop, gapped/stalled stream, mid-byte reset.
module tb_lfsr_byte_packer;

  logic       clk;
  logic       rst;
  logic       bit_in;
  logic       bit_valid;
  logic       byte_ready;
  logic       clear_ovf;

  logic [7:0] byte_out_m, byte_out_l;
  logic       byte_valid_m, byte_valid_l;
  logic [2:0] fill_m, fill_l;
  logic [2:0] bit_count_m, bit_count_l;
  logic       overflow_m, overflow_l;

  int n_chk  = 0;
  int n_pass = 0;

  lfsr_byte_packer #(.DEPTH(4), .MSB_FIRST(1'b1)) u_msb (
    .clk_i        (clk),
    .rst_i        (rst),
    .bit_in_i     (bit_in),
    .bit_valid_i  (bit_valid),
    .byte_out_o   (byte_out_m),
    .byte_valid_o (byte_valid_m),
    .byte_ready_i (byte_ready),
    .fill_level_o (fill_m),
    .bit_count_o  (bit_count_m),
    .overflow_o   (overflow_m),
    .clear_ovf_i  (clear_ovf)
  );

  lfsr_byte_packer #(.DEPTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk_i        (clk),
    .rst_i        (rst),
    .bit_in_i     (bit_in),
    .bit_valid_i  (bit_valid),
    .byte_out_o   (byte_out_l),
    .byte_valid_o (byte_valid_l),
    .byte_ready_i (byte_ready),
    .fill_level_o (fill_l),
    .bit_count_o  (bit_count_l),
    .overflow_o   (overflow_l),
    .clear_ovf_i  (clear_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Inputs change and outputs are sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; bit_valid = 1'b0; byte_ready = 1'b0; clear_ovf = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Feed one byte in MSB-first order; optionally pop on the edge of the final bit.
  task automatic send_byte(input logic [7:0] b, input logic pop_last);
    for (int i = 0; i < 8; i++) begin
      bit_valid = 1'b1;
      bit_in    = b[7-i];
      if (i == 7) byte_ready = pop_last;
      tick();
    end
    bit_valid  = 1'b0;
    byte_ready = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] exp);
    check(tag, {24'h0, byte_out_m}, {24'h0, exp});
    byte_ready = 1'b1;
    tick();
    byte_ready = 1'b0;
  endtask

  logic [7:0] pattern;
  logic [7:0] pm;
  logic [7:0] held;
  logic [7:0] exp_q[$];
  logic       stall_prev;
  logic       vld, rdy, b;
  int         cnt_m;
  int         popped;

  initial begin
    rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b1; byte_ready = 1'b0; clear_ovf = 1'b0;
    @(negedge clk);

    // Reset with bit_valid high and random bits
    for (int i = 0; i < 2; i++) begin
      bit_in = 1'($urandom);
      tick();
      check("rst_fill",  {29'h0, fill_m}, 32'd0);
      check("rst_valid", {31'h0, byte_valid_m}, 32'd0);
      check("rst_byte",  {24'h0, byte_out_m}, 32'd0);
      check("rst_bcnt",  {29'h0, bit_count_m}, 32'd0);
      check("rst_ovf",   {31'h0, overflow_m}, 32'd0);
    end
    rst = 1'b0; bit_valid = 1'b0;
    tick();
    check("post_rst_fill", {29'h0, fill_m}, 32'd0);
    check("post_rst_bcnt", {29'h0, bit_count_m}, 32'd0);

    // Packing order: 1,0,1,1,0,0,1,0 -> B2 (MSB first) / 4D (LSB first)
    pattern = 8'b1011_0010;
    for (int i = 0; i < 8; i++) begin
      bit_valid = 1'b1;
      bit_in    = pattern[7-i];
      tick();
      if (i == 2) check("bcnt_mid", {29'h0, bit_count_m}, 32'd3);
    end
    bit_valid = 1'b0;
    check("msb_valid", {31'h0, byte_valid_m}, 32'd1);
    check("msb_byte",  {24'h0, byte_out_m}, 32'hB2);
    check("msb_fill",  {29'h0, fill_m}, 32'd1);
    check("lsb_byte",  {24'h0, byte_out_l}, 32'h4D);
    check("lsb_fill",  {29'h0, fill_l}, 32'd1);
    check("bcnt_wrap", {29'h0, bit_count_m}, 32'd0);
    tick();
    check("hold_byte", {24'h0, byte_out_m}, 32'hB2);
    byte_ready = 1'b1;
    tick();
    byte_ready = 1'b0;
    check("pop_fill",  {29'h0, fill_m}, 32'd0);
    check("empty_byte", {24'h0, byte_out_m}, 32'h00);
    byte_ready = 1'b1;
    tick();
    byte_ready = 1'b0;
    check("pop_empty_fill", {29'h0, fill_m}, 32'd0);

    // Fill to DEPTH, overflow on the fifth byte, then drain in order
    do_reset();
    for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b0);
    check("full_fill", {29'h0, fill_m}, 32'd4);
    check("full_ovf",  {31'h0, overflow_m}, 32'd0);
    clear_ovf = 1'b1;
    send_byte(8'h05, 1'b0);
    clear_ovf = 1'b0;
    check("drop_fill", {29'h0, fill_m}, 32'd4);
    check("drop_ovf",  {31'h0, overflow_m}, 32'd1);
    pop_expect("drain0", 8'h01);
    pop_expect("drain1", 8'h02);
    pop_expect("drain2", 8'h03);
    pop_expect("drain3", 8'h04);
    check("drained_fill", {29'h0, fill_m}, 32'd0);
    check("ovf_sticky",   {31'h0, overflow_m}, 32'd1);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    check("ovf_clear", {31'h0, overflow_m}, 32'd0);

    // Full FIFO with a pop on the completing edge accepts the push
    for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i), 1'b0);
    send_byte(8'h14, 1'b1);
    check("fullpop_fill", {29'h0, fill_m}, 32'd4);
    check("fullpop_ovf",  {31'h0, overflow_m}, 32'd0);
    pop_expect("fullpop0", 8'h11);
    pop_expect("fullpop1", 8'h12);
    pop_expect("fullpop2", 8'h13);
    pop_expect("fullpop3", 8'h14);
    check("fullpop_empty", {29'h0, fill_m}, 32'd0);

    // Gapped input with random stalls against a reference packer
    do_reset();
    cnt_m = 0; pm = 8'h00; stall_prev = 1'b0; held = 8'h00; popped = 0;
    for (int i = 0; i < 96; i++) begin
      check("gap_bcnt", {29'h0, bit_count_m}, 32'(cnt_m));
      if (stall_prev) check("stall_stable", {24'h0, byte_out_m}, {24'h0, held});
      vld = 1'(i % 2);
      rdy = ($urandom_range(0, 2) != 0);
      b   = 1'($urandom);
      if (byte_valid_m && rdy) begin
        check("gap_pop", {24'h0, byte_out_m}, (exp_q.size() > 0) ? {24'h0, exp_q.pop_front()} : 32'h100);
        popped++;
      end
      stall_prev = byte_valid_m && !rdy;
      held       = byte_out_m;
      bit_valid  = vld; bit_in = b; byte_ready = rdy;
      if (vld) begin
        pm = {pm[6:0], b};
        cnt_m++;
        if (cnt_m == 8) begin
          exp_q.push_back(pm);
          cnt_m = 0;
        end
      end
      tick();
    end
    bit_valid = 1'b0; byte_ready = 1'b1;
    for (int i = 0; i < 16 && byte_valid_m; i++) begin
      check("gap_drain", {24'h0, byte_out_m}, (exp_q.size() > 0) ? {24'h0, exp_q.pop_front()} : 32'h100);
      popped++;
      tick();
    end
    byte_ready = 1'b0;
    check("gap_count", 32'(popped), 32'd6);
    check("gap_left",  32'(exp_q.size()), 32'd0);
    check("gap_ovf",   {31'h0, overflow_m}, 32'd0);

    // Reset mid-byte discards the partial
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bit_valid = 1'b1; bit_in = 1'b1;
      tick();
    end
    check("mid_bcnt5", {29'h0, bit_count_m}, 32'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0; bit_valid = 1'b0;
    check("mid_bcnt0", {29'h0, bit_count_m}, 32'd0);
    send_byte(8'hC3, 1'b0);
    check("mid_fill", {29'h0, fill_m}, 32'd1);
    pop_expect("mid_byte", 8'hC3);
    check("mid_empty", {29'h0, fill_m}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
